// File: rtl/dm_pkg.sv
// Shared definitions for the dm_subword data memory.
// Holds the access-op encodings and the controller state type.
package dm_pkg;

    localparam logic [2:0] MEM_OP_WORD  = 3'b000;
    localparam logic [2:0] MEM_OP_HALF  = 3'b001;
    localparam logic [2:0] MEM_OP_HALFU = 3'b010;
    localparam logic [2:0] MEM_OP_BYTE  = 3'b011;
    localparam logic [2:0] MEM_OP_BYTEU = 3'b100;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane merge for stores, lane extract/extend for loads,
// plus misalignment and illegal-op detection. Purely combinational.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_off,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_illegal
);

    logic        w_is_word;
    logic        w_is_half;
    logic        w_is_byte;
    logic        w_sext;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_is_word = (i_op == MEM_OP_WORD);
    assign w_is_half = (i_op == MEM_OP_HALF) || (i_op == MEM_OP_HALFU);
    assign w_is_byte = (i_op == MEM_OP_BYTE) || (i_op == MEM_OP_BYTEU);
    assign w_sext    = (i_op == MEM_OP_HALF) || (i_op == MEM_OP_BYTE);

    assign w_shifted = i_old >> {i_off, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_off[1] ? i_old[31:16] : i_old[15:0];

    always_comb begin
        o_merged     = i_old;
        o_rdata      = '0;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        unique case (1'b1)
            w_is_word: begin
                o_merged     = i_wdata;
                o_rdata      = i_old;
                o_misaligned = |i_off;
            end
            w_is_half: begin
                o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
                o_rdata = {{16{w_sext & w_half[15]}}, w_half};
                o_misaligned = i_off[0];
            end
            w_is_byte: begin
                o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
                o_rdata = {{24{w_sext & w_byte[7]}}, w_byte};
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_subword.sv
// Data memory with sub-word access, fixed latency and post-reset zero sweep.
// Define DM_TRACE_EN to print a trace line for every committed store.
module dm_subword
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [31:0]   r_mem [DEPTH_WORDS];
    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [2:0]    r_op;
    logic [1:0]    r_lane;
    logic [AW-1:0] r_idx;
    logic          r_oor;
    logic [31:0]   r_wdata;

    logic [31:0] w_off;
    logic        w_oor;
    logic [31:0] w_old;
    logic [31:0] w_merged;
    logic [31:0] w_rdata;
    logic        w_mis;
    logic        w_ill;
    logic        w_err;
    logic        w_commit;

    assign w_off    = req_addr - ADDR_BASE;
    assign w_oor    = (w_off[31:2] >= 30'(DEPTH_WORDS));
    assign w_old    = r_mem[r_idx];
    assign w_err    = r_oor | w_mis | w_ill;
    assign w_commit = (r_state == BUSY) && (r_cnt == 4'd1);

    dm_lane_unit u_lane (
        .i_old        (w_old),
        .i_wdata      (r_wdata),
        .i_op         (r_op),
        .i_off        (r_lane),
        .o_merged     (w_merged),
        .o_rdata      (w_rdata),
        .o_misaligned (w_mis),
        .o_illegal    (w_ill)
    );

`ifdef DM_TRACE_EN
    logic [31:0] r_pc;
    logic [31:0] w_waddr;
    assign w_waddr = ADDR_BASE + (32'(r_idx) << 2);
`else
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

    // Array has no reset; the CLEAR sweep zero-fills it instead.
    always_ff @(posedge Clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_commit && r_we && !w_err) begin
            r_mem[r_idx] <= w_merged;
`ifdef DM_TRACE_EN
            $display("@%h: *%h <= %h", r_pc, w_waddr, w_merged);
`endif
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= CLEAR;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_op       <= '0;
            r_lane     <= '0;
            r_idx      <= '0;
            r_oor      <= 1'b0;
            r_wdata    <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
`ifdef DM_TRACE_EN
            r_pc       <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            unique case (r_state)
                CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == AW'(DEPTH_WORDS - 1)) begin
                        r_state   <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_op      <= req_op;
                        r_lane    <= w_off[1:0];
                        r_idx     <= w_off[AW+1:2];
                        r_oor     <= w_oor;
                        r_wdata   <= req_wdata;
                        r_cnt     <= LAT;
                        req_ready <= 1'b0;
                        r_state   <= BUSY;
`ifdef DM_TRACE_EN
                        r_pc      <= req_pc;
`endif
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd1) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= w_err;
                        resp_rdata <= (w_err || r_we) ? 32'd0 : w_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state    <= IDLE;
                    req_ready  <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_subword.sv
// Scoreboard bench for dm_subword: byte-array reference model,
// directed cases plus randomized loads/stores.
module tb_dm_subword;

    localparam int          DEPTH = 8;
    localparam int          LAT   = 3;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        Clk;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dm_subword #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_BASE   (BASE),
        .LATENCY     (LAT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        time         t;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mb[DEPTH*4];
    int         checks = 0;
    int         passed = 0;
    int         pulses = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'h00;
    endtask

    // Reference: access size from op, error rules, byte-array read/write.
    task automatic model(input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err);
        logic [31:0] off;
        int size;
        off = addr - BASE;
        size = (op == 3'd0) ? 4 : (op <= 3'd2) ? 2 : (op <= 3'd4) ? 1 : 0;
        rd = 32'd0;
        err = (size == 0) || ((off >> 2) >= DEPTH) || ((off % size) != 0);
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++)
                    mb[off + k] = wdata[8*k +: 8];
            end else begin
                for (int k = 0; k < size; k++)
                    rd = rd | (32'(mb[off + k]) << (8*k));
                if (op == 3'd1 && rd[15]) rd = rd | 32'hFFFF_0000;
                if (op == 3'd3 && rd[7])  rd = rd | 32'hFFFF_FF00;
            end
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset && resp_valid) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got pulse want none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", resp_rdata, e.rdata);
                chk("err", 32'(resp_err), 32'(e.err));
                checks++;
                if ($time == e.t) passed++;
                else $display("FAIL latency: got t=%0t want t=%0t", $time, e.t);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc, input bit hold,
                         input bit push);
        int n;
        exp_t e;
        n = 0;
        @(negedge Clk);
        while (!req_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            $display("FAIL ready_timeout: got ready=0 want ready=1");
            return;
        end
        model(we, op, addr, wdata, e.rdata, e.err);
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = pc;
        req_valid = 1'b1;
        @(posedge Clk);
        e.t = $time + LAT*10 + 5;
        if (push) sb.push_back(e);
        if (hold) begin
            for (int i = 0; i <= LAT; i++) begin
                @(negedge Clk);
                chk("ready_busy", 32'(req_ready), 32'd0);
                req_we    = 1'($urandom);
                req_op    = 3'($urandom);
                req_addr  = $urandom_range(0, DEPTH*4 - 1);
                req_wdata = $urandom;
            end
        end
        @(negedge Clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        do begin
            @(posedge Clk);
            #1;
            n++;
        end while (!req_ready && n < 100);
        chk("clear_cycles", 32'(n), 32'(DEPTH));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int p0;
        Reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_op    = 3'd0;
        req_addr  = '0;
        req_wdata = '0;
        req_pc    = '0;
        model_clear();

        @(negedge Clk);
        @(negedge Clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        Reset = 1'b0;
        wait_clear();

        issue(0, 3'd0, 32'h0, 0, 32'h1000, 0, 1);
        issue(1, 3'd0, 32'h8, 32'hDEADBEEF, 32'h1004, 0, 1);
        issue(1, 3'd3, 32'h9, 32'h12, 32'h1008, 1, 1);
        issue(0, 3'd0, 32'h8, 0, 32'h100C, 0, 1);
        issue(0, 3'd3, 32'hB, 0, 32'h1010, 1, 1);
        issue(0, 3'd2, 32'hA, 0, 32'h1014, 0, 1);
        issue(1, 3'd0, 32'h10, 32'hCAFEF00D, 32'h3000, 0, 1);

        issue(0, 3'd0, 32'h6, 0, 32'h2000, 0, 1);
        issue(1, 3'd1, 32'h3, 32'hFFFF, 32'h2004, 0, 1);
        issue(0, 3'd7, 32'h8, 0, 32'h2008, 0, 1);
        issue(1, 3'd7, 32'h8, 32'h1, 32'h200C, 0, 1);
        issue(0, 3'd0, BASE + DEPTH*4, 0, 32'h2010, 0, 1);
        issue(1, 3'd0, BASE + DEPTH*4, 32'h77, 32'h2014, 0, 1);
        for (int i = 0; i < DEPTH; i++)
            issue(0, 3'd0, 32'(i*4), 0, 32'h2100, 0, 1);

        for (int i = 0; i < 200; i++)
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, DEPTH*4 + 7), $urandom,
                  $urandom, ($urandom_range(0, 3) == 0), 1);
        drain();

        issue(1, 3'd0, 32'h4, 32'h55, 32'h4000, 0, 0);
        p0 = pulses;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_clear();
        wait_clear();
        chk("no_pulse_reset", 32'(pulses), 32'(p0));
        issue(0, 3'd0, 32'h4, 0, 32'h4004, 0, 1);
        for (int i = 0; i < DEPTH; i++)
            issue(0, 3'd0, 32'(i*4), 0, 32'h4100, 0, 1);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
